// File: rtl/cpu_types_pkg.sv
// Shared CPU types: icache FSM state and frame layout.
// Frame tag is sized for the smallest index (30 bits); unused MSBs stay zero.
package cpu_types_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] data;
  } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame.
// Ports: CLK/nRST, datapath imemREN/imemaddr -> ihit/imemload,
// memory side iREN/iaddr -> iwait/iload.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state, state_n;
  logic [31:0] miss_addr;
  logic [NSETS-1:0] valid;
  logic [29:0] tags [NSETS];
  logic [31:0] data [NSETS];

  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  icache_frame_t frame;
  logic hit, fill;
  logic unused_bits;

  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];

  // The low address bits only select bytes within a word.
  assign unused_bits = ^{imemaddr[1:0], miss_addr[1:0]};

  assign frame = '{
    valid: valid[idx],
    tag:   tags[idx],
    data:  data[idx]
  };

  assign hit = imemREN & frame.valid
             & (frame.tag == 30'(tag));

  always_comb begin
    state_n  = state;
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    fill     = 1'b0;
    unique case (state)
      IDLE: begin
        ihit = hit;
        if (hit) imemload = frame.data;
        if (imemREN && !hit) state_n = FETCH;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_addr[31:2], 2'b00};
        // No forwarding: the word is seen
        // through a hit on the next cycle.
        if (!iwait) begin
          fill    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= 32'h0;
      valid     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == FETCH)
        miss_addr <= imemaddr;
      if (fill)
        valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset; valid gates them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fill_idx] <= 30'(fill_tag);
      data[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache (NSETS=16).
// Scoreboard queue holds expected words, popped on ihit.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks;
  int errors;

  logic [31:0] exp_q [$];
  bit          mvalid [16];
  logic [25:0] mtag [16];

  icache #(.NSETS(16)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .imemREN (imemREN),
    .imemaddr(imemaddr),
    .ihit    (ihit),
    .imemload(imemload),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h4) return 32'h2001_0005;
    return (w * 32'h0000_9E37) ^ 32'h1234_5678;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a);
    mvalid[a[5:2]] = 1'b1;
    mtag[a[5:2]]   = a[31:6];
  endtask

  task automatic pop_check(input string nm);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected ihit data %h", nm, imemload);
    end else begin
      e = exp_q.pop_front();
      if (imemload !== e) begin
        errors++;
        $display("FAIL %s: imemload %h want %h",
                 nm, imemload, e);
      end
    end
  endtask

  // One request held until ihit; memory side served
  // with `waits` busy cycles per fill.
  task automatic access(
    input  logic [31:0] addr,
    input  int          waits,
    output int          lat,
    output int          ren_cyc
  );
    int fc;
    bit got, bad, exp_miss, missed;
    exp_miss = !(mvalid[addr[5:2]] &&
                 mtag[addr[5:2]] == addr[31:6]);
    imemREN  = 1'b1;
    imemaddr = addr;
    exp_q.push_back(mem(addr));
    fc = 0; got = 0; bad = 0;
    ren_cyc = 0; lat = -1;
    for (int c = 0; c < 40 && !got; c++) begin
      if (iREN) begin
        ren_cyc++;
        if (iaddr !== {addr[31:2], 2'b00}) bad = 1;
        iwait = (fc < waits);
        iload = iwait ? 32'hx : mem(iaddr);
        fc++;
      end else begin
        iwait = 1'b1;
        iload = 32'hx;
      end
      #1;
      if (ihit) begin
        got = 1;
        lat = c;
        pop_check("access_data");
      end
      step();
    end
    iwait = 1'b1;
    iload = 32'hx;
    if (!got) begin
      checks++;
      errors++;
      void'(exp_q.pop_back());
      $display("FAIL access_timeout: addr %h no ihit", addr);
    end
    missed = (lat != 0);
    checks++;
    if (missed !== exp_miss) begin
      errors++;
      $display("FAIL access_miss: addr %h miss %0d want %0d",
               addr, missed, exp_miss);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL access_iaddr: addr %h bad iaddr seen", addr);
    end
    model_fill(addr);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    imemREN = 1'b0;
    imemaddr = 32'h0;
    iwait = 1'b1;
    iload = 32'hx;
    model_clear();
    step();
    step();
    checks++;
    if ({ihit, iREN} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctl: ihit %b iREN %b want 0 0",
               ihit, iREN);
    end
    checks++;
    if (imemload !== 32'h0 || iaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: imemload %h iaddr %h want 0 0",
               imemload, iaddr);
    end
    nRST = 1'b1;
    step();
    checks++;
    if ({ihit, iREN} !== 2'b00 || iaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_after: ihit %b iREN %b iaddr %h",
               ihit, iREN, iaddr);
    end
  endtask

  task automatic test_cold_miss();
    int lat, rc;
    access(32'h0000_0004, 3, lat, rc);
    checks++;
    if (rc != 4) begin
      errors++;
      $display("FAIL cold_iren: cycles %0d want 4", rc);
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL cold_lat: ihit cycle %0d want 5", lat);
    end
  endtask

  task automatic test_hit_reuse();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0004;
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back(32'h2001_0005);
      #1;
      checks++;
      if (ihit !== 1'b1 || iREN !== 1'b0) begin
        errors++;
        void'(exp_q.pop_back());
        $display("FAIL reuse_hit: ihit %b iREN %b want 1 0",
                 ihit, iREN);
      end else begin
        pop_check("reuse_data");
      end
      step();
    end
  endtask

  task automatic test_conflict();
    int lat, rc;
    access(32'h0000_0000, 0, lat, rc);
    checks++;
    if (lat != 2 || rc != 1) begin
      errors++;
      $display("FAIL conflict_lat: lat %0d iren %0d want 2 1",
               lat, rc);
    end
    access(32'h0000_0040, 0, lat, rc);
    access(32'h0000_0000, 1, lat, rc);
    access(32'h0000_0000, 0, lat, rc);
  endtask

  task automatic test_addr_change();
    int lat, rc;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0010;
    iwait    = 1'b1;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      errors++;
      $display("FAIL chg_miss: ihit %b want 0", ihit);
    end
    step();
    imemaddr = 32'h0000_0020;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (iREN !== 1'b1 || iaddr !== 32'h10) begin
        errors++;
        $display("FAIL chg_hold: iREN %b iaddr %h want 1 10",
                 iREN, iaddr);
      end
      step();
    end
    iwait = 1'b0;
    iload = mem(32'h10);
    step();
    iwait = 1'b1;
    iload = 32'hx;
    #1;
    checks++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      errors++;
      $display("FAIL chg_reeval: ihit %b iREN %b want 0 0",
               ihit, iREN);
    end
    step();
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h20) begin
      errors++;
      $display("FAIL chg_new: iREN %b iaddr %h want 1 20",
               iREN, iaddr);
    end
    iwait = 1'b0;
    iload = mem(32'h20);
    step();
    iwait = 1'b1;
    iload = 32'hx;
    model_fill(32'h10);
    model_fill(32'h20);
    access(32'h0000_0010, 0, lat, rc);
    access(32'h0000_0020, 0, lat, rc);
  endtask

  task automatic test_reset_mid_fetch();
    int lat, rc;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0080;
    iwait    = 1'b1;
    step();
    #1;
    checks++;
    if (iREN !== 1'b1) begin
      errors++;
      $display("FAIL rst_fetch: iREN %b want 1", iREN);
    end
    iload = mem(32'h80);
    nRST  = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || iaddr !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: iREN %b iaddr %h want 0 0",
               iREN, iaddr);
    end
    iwait = 1'b0;
    step();
    iwait = 1'b1;
    iload = 32'hx;
    nRST  = 1'b1;
    model_clear();
    access(32'h0000_0080, 0, lat, rc);
    access(32'h0000_0004, 0, lat, rc);
  endtask

  task automatic test_ren_low();
    imemREN  = 1'b0;
    imemaddr = 32'h0000_0080;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (ihit !== 1'b0 || imemload !== 32'h0 ||
          iREN !== 1'b0) begin
        errors++;
        $display("FAIL ren_low: ihit %b load %h iREN %b",
                 ihit, imemload, iREN);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int lat, rc;
    logic [31:0] a;
    for (int n = 0; n < 10; n++) begin
      a = 32'($urandom_range(0, 47)) << 2;
      access(a, int'($urandom_range(0, 2)), lat, rc);
      access(a, 0, lat, rc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cold_miss();
    test_hit_reuse();
    test_conflict();
    test_addr_change();
    test_reset_mid_fetch();
    test_ren_low();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries want 0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001: Parameter NSETS, default 16, number of direct-mapped frames; power of two, 2..256.
REQ-002: CLK  input  1  clock; all state updates on rising edge.
REQ-003: nRST  input  1  reset, asynchronous, active-low.
REQ-004: imemREN  input  1  datapath instruction read request.
REQ-005: imemaddr  input  32  datapath instruction byte address (PC).
REQ-006: ihit  output  1  requested word valid on imemload this cycle.
REQ-007: imemload  output  32  instruction word returned to datapath.
REQ-008: iREN  output  1  fill read request to memory controller.
REQ-009: iaddr  output  32  fill word address to memory controller.
REQ-010: iwait  input  1  memory busy; fill data valid in the cycle iwait=0 while iREN=1.
REQ-011: iload  input  32  fill data from memory controller.

Function
REQ-012: Address split: byte offset [1:0] ignored; index [IDX_W+1:2], IDX_W=log2(NSETS); tag [31:IDX_W+2].
REQ-013: Frame state: valid bit, tag, 32-bit data per index.
REQ-014: Hit = imemREN & valid[idx] & (tag[idx]==addr tag), combinational, in state IDLE only.
REQ-015: On hit: ihit=1, imemload=data[idx] same cycle; no state change.
REQ-016: ihit SHALL be 0 whenever imemREN=0, state is FETCH, or lookup misses.
REQ-017: imemload SHALL be data[idx] when ihit=1, else 32'h0.
REQ-018: FSM states IDLE, FETCH.
REQ-019: IDLE -> FETCH when imemREN=1 and lookup misses; miss address latched into miss_addr register at that edge.
REQ-020: In FETCH: iREN=1, iaddr={miss_addr[31:2],2'b00}; in IDLE: iREN=0, iaddr=32'h0.
REQ-021: In FETCH with iwait=0: write valid=1, tag and iload into frame at miss_addr index; FETCH -> IDLE at same edge.
REQ-022: In FETCH with iwait=1: hold state, hold iREN/iaddr.
REQ-023: Miss latency: ihit no earlier than cycle after fill completes (no data forwarding); with iwait low on first FETCH cycle, miss-to-ihit = 2 cycles.
REQ-024: imemaddr change or imemREN drop during FETCH SHALL NOT abort or redirect the fill; fill completes to miss_addr, then IDLE re-evaluates new address.
REQ-025: Fill to occupied index SHALL overwrite tag and data (conflict eviction); no write-back, cache is read-only.
REQ-026: Repeated access to same address after fill SHALL hit every cycle with no iREN activity.
REQ-027: Unmapped/undefined iload values (X) SHALL only enter array when iwait=0 in FETCH.

Reset
REQ-028: nRST low SHALL immediately clear all valid bits, force state IDLE, miss_addr=0.
REQ-029: During and after reset until first request: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-030: Reset asserted mid-FETCH SHALL abandon the fill; no frame written.
REQ-031: Tag and data arrays need not be reset; only valid bits.

Structure
REQ-032: icache_state_t (IDLE, FETCH) and icache_frame_t (valid, tag, data) typedefs SHALL live in cpu_types_pkg.
REQ-033: Index/tag widths derived from NSETS inside the module via localparams.
REQ-034: No sub-module; frame array, lookup, and FSM are a single module.

Verification
REQ-035: Cold miss: reset, imemREN=1, imemaddr=0x0000_0004, iwait=1 for 3 cycles then 0 with iload=0x2001_0005 -> iREN high 4 cycles, iaddr=0x0000_0004, ihit=1 with imemload=0x2001_0005 on following cycle.
REQ-036: Hit reuse: after REQ-035, hold address 5 cycles -> ihit=1 all 5 cycles, iREN=0 throughout.
REQ-037: Conflict: NSETS=16, fill 0x0000_0000 then 0x0000_0040 (same index 0) -> second access misses; re-access 0x0000_0000 misses again.
REQ-038: Address change mid-fill: miss on 0x10, change imemaddr to 0x20 during iwait=1 -> iaddr stays 0x10, frame 4 filled, then new miss issued for 0x20.
REQ-039: Reset mid-FETCH: assert nRST low with iREN=1 -> iREN=0 immediately; after release, same address misses again.
REQ-040: imemREN=0 with valid matching frame -> ihit=0, imemload=0, no fill.
